if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the core_lapido pipeline. It owns the PC and fetches word-addressed instructions over a req/ack instruction-memory port. It drives the instruction word and PC+1 into the decode stage and accepts redirects: jumps from decode and taken branches from MEM. It honours the hazard-unit stall through a one-entry hold buffer, so a returned word is never lost.

Parameters:
PC_WIDTH, 32, PC and address width (= `PC_WIDTH)
INSTR_WIDTH, 32, instruction width (= `INSTRUCTION_WIDTH)
RESET_PC, 0, first fetch address after reset
NOP_WORD, 32'h0000_0000, bubble inserted on flush or miss

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
stall_pipeline  in  1  hazard unit: hold decode input
is_jump  in  1  decode: unconditional jump this cycle
jump_addr  in  PC_WIDTH  decode: jump target
branch_taken  in  1  MEM: pc-relative branch resolved taken
branch_addr  in  PC_WIDTH  MEM: branch target
imem_req  out  1  fetch request
imem_addr  out  PC_WIDTH  fetch address, equals pc
imem_ack  in  1  memory: imem_rdata valid for imem_addr this cycle
imem_rdata  in  INSTR_WIDTH  fetched word
instruction  out  INSTR_WIDTH  to decode
next_pc  out  PC_WIDTH  address of instruction + 1, to decode
valid  out  1  instruction is a real fetch, not a bubble

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=S_FETCH, instruction=NOP_WORD, next_pc=0, valid=0, hold_valid=0. imem_req is 0 while rst is low.
- imem_req=1 only in S_FETCH. imem_addr=pc combinationally. Memory acks the address presented in the ack cycle, so the address may change while req is high and no ack has arrived. Zero or more wait cycles are allowed.
- Redirect precedence: branch_taken > is_jump. Target = branch_addr if branch_taken, else jump_addr. Redirect beats stall.
- On redirect, in any state:
  - pc <= target; state <= S_FETCH; hold_valid <= 0.
  - instruction <= NOP_WORD; valid <= 0.
  - An imem_ack in the same cycle is discarded.
- S_FETCH, ack, no stall:
  - instruction <= imem_rdata; next_pc <= pc+1; valid <= 1; pc <= pc+1.
  - Stays in S_FETCH, giving one instruction per cycle at zero wait.
- S_FETCH, ack, stall:
  - hold_instr <= imem_rdata; hold_pc <= pc; hold_valid <= 1; pc <= pc+1; state <= S_HOLD.
  - Outputs are unchanged.
- S_FETCH, no ack, no stall: instruction <= NOP_WORD; valid <= 0. pc is unchanged.
- S_FETCH, no ack, stall: outputs held.
- S_HOLD: imem_req=0; outputs held while stall=1. When stall=0: instruction <= hold_instr; next_pc <= hold_pc+1; valid <= 1; hold_valid <= 0; state <= S_FETCH.
- Latency: ack at edge N puts the word on instruction after edge N. Redirect at edge N makes imem_addr=target after edge N.
- PC arithmetic is modulo 2^PC_WIDTH; all-ones+1 wraps to 0 with no flag.
- Reset asserted mid-wait or in S_HOLD abandons everything. The first post-reset request is RESET_PC.

Decomposition:
- PC_WIDTH, INSTRUCTION_WIDTH, RESET_PC and the NOP encoding live in lapido_defs.v. The state encodings S_FETCH/S_HOLD also go there as `defines.
- One sub-module: if_hold_buffer, the one-entry hold register with instr, pc and valid plus load/clear. PC register and FSM stay in if_stage.

Test Plan:
- Reset, then zero-wait memory returning mem[a]=a+0x100 → imem_addr 0,1,2,...; instruction 0x100,0x101,0x102 on successive cycles; next_pc 1,2,3; valid=1.
- Memory with 2 wait cycles at addr 0 → two NOP_WORD cycles with valid=0, then 0x100 with next_pc=1; imem_addr stays 0 until ack.
- Ack at addr 4 with stall_pipeline=1 for 3 cycles → outputs frozen, imem_req=0, state S_HOLD; stall drops → instruction=0x104, next_pc=5, then fetch resumes at addr 5.
- is_jump=1, jump_addr=0x40 with ack in the same cycle → ack data dropped, instruction=NOP_WORD, valid=0, next imem_addr=0x40.
- branch_taken=1 (0x80), is_jump=1 (0x40) and stall=1 all at once → imem_addr=0x80, hold buffer cleared, bubble output.
- rst pulled low during a wait at addr 7, then released → imem_req=0 during reset; first request at RESET_PC; instruction=NOP_WORD, valid=0 until the first ack.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and state encoding for the core_lapido instruction-fetch stage.
package if_stage_pkg;

  localparam int          DEF_PC_WIDTH    = 32;
  localparam int          DEF_INSTR_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_WORD    = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry hold register catching a fetched word while decode is stalled.
module if_hold_buffer #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   clear,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [PC_WIDTH-1:0]    load_pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   valid
);

  // NOTE: the data fields are reset as well; for a single entry this is
  // cheap and keeps the outputs free of X after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, takes redirects
// and parks a returned word in the hold buffer while decode is stalled.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                     PC_WIDTH    = DEF_PC_WIDTH,
  parameter int                     INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = PC_WIDTH'(DEF_RESET_PC),
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = INSTR_WIDTH'(DEF_NOP_WORD)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_pipeline,
  input  logic                   is_jump,
  input  logic [PC_WIDTH-1:0]    jump_addr,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_addr,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    next_pc,
  output logic                   valid
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  if_state_e                state, state_next;
  logic [PC_WIDTH-1:0]      pc, pc_next, next_pc_d;
  logic [INSTR_WIDTH-1:0]   instr_d;
  logic                     valid_d;
  logic                     hold_load, hold_clear;
  logic [INSTR_WIDTH-1:0]   hold_instr;
  logic [PC_WIDTH-1:0]      hold_pc;
  logic                     hold_valid;
  logic                     redirect;
  logic [PC_WIDTH-1:0]      target;

  // Branches resolve later in the pipe than jumps, so they win.
  assign redirect = branch_taken | is_jump;
  assign target   = branch_taken ? branch_addr : jump_addr;

  assign imem_req  = rst && (state == S_FETCH);
  assign imem_addr = pc;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    pc_next    = pc;
    instr_d    = instruction;
    next_pc_d  = next_pc;
    valid_d    = valid;
    hold_load  = 1'b0;
    hold_clear = 1'b0;

    if (redirect) begin
      pc_next    = target;
      state_next = S_FETCH;
      hold_clear = 1'b1;
      instr_d    = NOP_WORD;
      valid_d    = 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            pc_next = pc + PC_ONE;
            if (stall_pipeline) begin
              hold_load  = 1'b1;
              state_next = S_HOLD;
            end else begin
              instr_d   = imem_rdata;
              next_pc_d = pc + PC_ONE;
              valid_d   = 1'b1;
            end
          end else if (!stall_pipeline) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall_pipeline) begin
            instr_d    = hold_instr;
            next_pc_d  = hold_pc + PC_ONE;
            valid_d    = hold_valid;
            hold_clear = 1'b1;
            state_next = S_FETCH;
          end
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instruction <= NOP_WORD;
      next_pc     <= '0;
      valid       <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instruction <= instr_d;
      next_pc     <= next_pc_d;
      valid       <= valid_d;
    end
  end

  if_hold_buffer #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .clear      (hold_clear),
    .load_instr (imem_rdata),
    .load_pc    (pc),
    .instr      (hold_instr),
    .pc         (hold_pc),
    .valid      (hold_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected words, a negedge
// monitor pops them whenever decode would consume (valid && !stall).
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_pipeline;
  logic        is_jump;
  logic [31:0] jump_addr;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] next_pc;
  logic        valid;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  bit          in_hold;
  bit          exp_valid;

  always #5 clk = ~clk;

  // Memory image: mem[a] = a + 0x100, answered for whatever address is shown.
  assign imem_rdata = imem_addr + 32'h100;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_pipeline (stall_pipeline),
    .is_jump        (is_jump),
    .jump_addr      (jump_addr),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .next_pc        (next_pc),
    .valid          (valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: decode consumes the presented word on an edge where stall is low.
  always @(negedge clk) begin
    if (rst && valid && !stall_pipeline) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%08h expected none at %0t", instruction, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instruction", instruction, e.instr);
        check("sb_next_pc", next_pc, e.npc);
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit ack, input bit stall, input bit jmp, input logic [31:0] jaddr,
                      input bit br, input logic [31:0] baddr);
    imem_ack       = ack;
    stall_pipeline = stall;
    is_jump        = jmp;
    jump_addr      = jaddr;
    branch_taken   = br;
    branch_addr    = baddr;
    #1;
    check("imem_req", 32'(imem_req), 32'(!in_hold));
    check("imem_addr", imem_addr, exp_pc);
    if (br || jmp) begin
      if (in_hold && sb.size() > 0) sb.delete(sb.size() - 1);
      if (stall && exp_valid && sb.size() > 0) sb.delete(0);
      exp_pc    = br ? baddr : jaddr;
      in_hold   = 1'b0;
      exp_valid = 1'b0;
    end else if (!in_hold) begin
      if (ack) begin
        sb.push_back('{instr: exp_pc + 32'h100, npc: exp_pc + 32'd1});
        exp_pc = exp_pc + 32'd1;
        if (stall) in_hold = 1'b1;
        else       exp_valid = 1'b1;
      end else if (!stall) begin
        exp_valid = 1'b0;
      end
    end else if (!stall) begin
      in_hold   = 1'b0;
      exp_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check("valid", 32'(valid), 32'(exp_valid));
    if (!exp_valid) check("bubble_instr", instruction, NOP);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; stall_pipeline = 1'b0; is_jump = 1'b0; jump_addr = '0;
    branch_taken = 1'b0; branch_addr = '0; imem_ack = 1'b0;
    exp_pc = 32'h0; in_hold = 1'b0; exp_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_instruction", instruction, NOP);
    check("rst_next_pc", next_pc, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    rst = 1'b1;

    // Zero-wait fetch of addresses 0,1,2
    repeat (3) step(1, 0, 0, '0, 0, '0);

    // Back to 0, then two wait cycles before the ack
    step(0, 0, 1, 32'h0, 0, '0);
    repeat (2) step(0, 0, 0, '0, 0, '0);
    repeat (4) step(1, 0, 0, '0, 0, '0);      // addresses 0..3

    // Ack at 4 under a three-cycle stall (acks while holding are ignored)
    repeat (3) step(1, 1, 0, '0, 0, '0);
    step(1, 0, 0, '0, 0, '0);                 // release 0x104
    step(1, 0, 0, '0, 0, '0);                 // resumes at 5

    // Jump with a same-cycle ack
    step(1, 0, 1, 32'h40, 0, '0);
    step(1, 0, 0, '0, 0, '0);                 // 0x140

    // Branch beats jump beats stall while a word sits in the hold buffer
    step(1, 1, 0, '0, 0, '0);                 // 0x141 into hold
    step(1, 1, 1, 32'h40, 1, 32'h80);
    step(1, 0, 0, '0, 0, '0);                 // 0x180

    // PC wrap at all-ones
    step(1, 0, 1, 32'hFFFF_FFFF, 0, '0);
    step(1, 0, 0, '0, 0, '0);                 // 0xFF, next_pc 0
    step(1, 0, 0, '0, 0, '0);                 // 0x100, next_pc 1

    // Reset in the middle of a wait at address 7
    step(0, 0, 1, 32'h7, 0, '0);
    repeat (2) step(0, 0, 0, '0, 0, '0);
    #1 rst = 1'b0;
    #1;
    check("midrst_imem_req", 32'(imem_req), 32'd0);
    check("midrst_imem_addr", imem_addr, 32'h0);
    check("midrst_valid", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_imem_req_edge", 32'(imem_req), 32'd0);
    #2 rst = 1'b1;
    exp_pc = 32'h0; in_hold = 1'b0; exp_valid = 1'b0;
    sb.delete();
    step(0, 0, 0, '0, 0, '0);                 // no ack yet: bubble
    step(1, 0, 0, '0, 0, '0);                 // 0x100 from RESET_PC

    repeat (2) step(0, 0, 0, '0, 0, '0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
